// File: rtl/mdu_iterative.sv
// Iterative RV32M/RV64M multiply/divide unit: one bit per cycle, fixed XLEN+1 cycle latency.
// Define MDU_DIV_EN to build the divider; without it, divide/remainder requests finish at once with `illegal`.
module mdu_iterative #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            illegal,
    output logic [1:0]      dbg_state
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(XLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     mcand_q, mcand_d;
    logic                neg_q, neg_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                done_q, done_d;
    logic                illegal_q, illegal_d;

    logic                accept;
    logic                a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_step;
    logic [2*XLEN-1:0]   mul_full;
    logic [XLEN-1:0]     mul_res;

    // The done cycle still counts as busy so the next start lands one cycle later.
    assign accept = (state_q == S_IDLE) && !done_q && start;

    assign a_sgn = funct3[2] ? ~funct3[0] : (funct3[1] ^ funct3[0]);
    assign b_sgn = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01);
    assign a_neg = a_sgn & a[XLEN-1];
    assign b_neg = b_sgn & b[XLEN-1];
    assign a_mag = a_neg ? ('0 - a) : a;
    assign b_mag = b_neg ? ('0 - b) : b;

    // acc = {partial product high, remaining multiplier bits}; shift right once per cycle.
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    assign mul_step = {mul_sum, acc_q[XLEN-1:1]};
    assign mul_full = neg_q ? ('0 - acc_q) : acc_q;
    assign mul_res  = (op_q[1:0] == 2'b00) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];

`ifdef MDU_DIV_EN
    logic [XLEN:0]       rem_shift;
    logic [XLEN:0]       div_diff;
    logic [2*XLEN-1:0]   div_step;
    logic [XLEN-1:0]     div_sel;
    logic [XLEN-1:0]     div_res;

    // acc = {remainder, dividend bits becoming quotient bits}. Since remainder < divisor,
    // the top bit of the XLEN+1-bit difference is exactly the borrow.
    assign rem_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_diff  = rem_shift - {1'b0, mcand_q};
    assign div_step  = {(div_diff[XLEN] ? rem_shift[XLEN-1:0] : div_diff[XLEN-1:0]),
                        acc_q[XLEN-2:0], ~div_diff[XLEN]};
    assign div_sel   = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    assign div_res   = neg_q ? ('0 - div_sel) : div_sel;
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        neg_d     = neg_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d    = funct3;
                    cnt_d   = CNT_INIT;
                    state_d = S_CALC;
                    if (funct3[2]) begin
`ifdef MDU_DIV_EN
                        acc_d   = {{XLEN{1'b0}}, a_mag};
                        mcand_d = b_mag;
                        // Forcing a positive quotient on b == 0 leaves the all-ones result intact.
                        neg_d   = funct3[1] ? a_neg : ((a_neg ^ b_neg) && (b != '0));
`else
                        state_d = S_FIN;
`endif
                    end else begin
                        acc_d   = {{XLEN{1'b0}}, b_mag};
                        mcand_d = a_mag;
                        neg_d   = a_neg ^ b_neg;
                    end
                end
            end
            S_CALC: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIN;
                end
`ifdef MDU_DIV_EN
                acc_d = op_q[2] ? div_step : mul_step;
`else
                acc_d = mul_step;
`endif
            end
            S_FIN: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
`ifdef MDU_DIV_EN
                result_d = op_q[2] ? div_res : mul_res;
`else
                result_d  = op_q[2] ? '0 : mul_res;
                illegal_d = op_q[2];
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            neg_q     <= 1'b0;
            cnt_q     <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            neg_q     <= neg_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign busy      = (state_q != S_IDLE) || done_q;
    assign done      = done_q;
    assign result    = result_q;
    assign illegal   = illegal_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed bench for mdu_iterative (XLEN=32); divide tests follow MDU_DIV_EN.
module tb_mdu_iterative;

    localparam int XLEN = 32;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            illegal;
    logic [1:0]      dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    mdu_iterative #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .funct3    (funct3),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .illegal   (illegal),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits one idle cycle, issues one op, scrambles inputs, and waits (bounded) for done.
    task automatic run_op(input logic [2:0] f, input logic [31:0] av, input logic [31:0] bv,
                          output logic [31:0] res, output int lat, output bit busy_ok,
                          output logic ill);
        tick();
        funct3 = f;
        a      = av;
        b      = bv;
        start  = 1'b1;
        tick();
        start   = 1'b0;
        funct3  = 3'($urandom_range(0, 7));
        a       = $urandom;
        b       = $urandom;
        lat     = 0;
        busy_ok = 1'b1;
        do begin
            tick();
            lat++;
            if (!busy) busy_ok = 1'b0;
        end while (!done && lat < 100);
        res = result;
        ill = illegal;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        start  = 1'b0;
        funct3 = '0;
        a      = '0;
        b      = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++;
        if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got %b want 0", illegal); end
        n_checks++;
        if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h want 0", result); end
    endtask

    task automatic test_mul();
        vec_t        v[8];
        logic [31:0] res;
        int          lat;
        bit          bok;
        logic        ill;
        v = '{'{3'b000, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB},
              '{3'b001, 32'h80000000,  32'h80000000, 32'h40000000},
              '{3'b011, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE},
              '{3'b010, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFF},
              '{3'b001, 32'hFFFFFFFF,  32'h00000001, 32'hFFFFFFFF},
              '{3'b011, 32'h12345678,  32'h00000010, 32'h00000001},
              '{3'b000, 32'h12345678,  32'h00000010, 32'h23456780},
              '{3'b010, 32'h00000002,  32'hFFFFFFFF, 32'h00000001}};
        for (int i = 0; i < 8; i++) begin
            run_op(v[i].f, v[i].a, v[i].b, res, lat, bok, ill);
            n_checks++;
            if (res !== v[i].exp) begin n_fail++; $display("FAIL mul[%0d] result got %h want %h", i, res, v[i].exp); end
            n_checks++;
            if (lat != 33) begin n_fail++; $display("FAIL mul[%0d] latency got %0d want 33", i, lat); end
            n_checks++;
            if (!bok) begin n_fail++; $display("FAIL mul[%0d] busy dropped got 0 want 1", i); end
            n_checks++;
            if (ill !== 1'b0) begin n_fail++; $display("FAIL mul[%0d] illegal got %b want 0", i, ill); end
        end
        tick();
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse got %b want 0", done); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_after_done got %b want 0", busy); end
    endtask

`ifdef MDU_DIV_EN
    task automatic test_div();
        vec_t        v[11];
        logic [31:0] res;
        int          lat;
        bit          bok;
        logic        ill;
        v = '{'{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD},
              '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF},
              '{3'b101, 32'd100,      32'd7,        32'd14},
              '{3'b111, 32'd100,      32'd7,        32'd2},
              '{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF},
              '{3'b110, 32'd5,        32'd0,        32'd5},
              '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000},
              '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000},
              '{3'b100, 32'hFFFFFFEC, 32'd0,        32'hFFFFFFFF},
              '{3'b110, 32'd7,        32'hFFFFFFFE, 32'd1},
              '{3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD}};
        for (int i = 0; i < 11; i++) begin
            run_op(v[i].f, v[i].a, v[i].b, res, lat, bok, ill);
            n_checks++;
            if (res !== v[i].exp) begin n_fail++; $display("FAIL div[%0d] result got %h want %h", i, res, v[i].exp); end
            n_checks++;
            if (lat != 33) begin n_fail++; $display("FAIL div[%0d] latency got %0d want 33", i, lat); end
            n_checks++;
            if (!bok || ill !== 1'b0) begin n_fail++; $display("FAIL div[%0d] busy_ok/illegal got %b/%b want 1/0", i, bok, ill); end
        end
    endtask
`else
    task automatic test_div_disabled();
        logic [31:0] res;
        int          lat;
        bit          bok;
        logic        ill;
        run_op(3'b100, 32'd100, 32'd7, res, lat, bok, ill);
        n_checks++;
        if (lat != 1) begin n_fail++; $display("FAIL nodiv_latency got %0d want 1", lat); end
        n_checks++;
        if (ill !== 1'b1) begin n_fail++; $display("FAIL nodiv_illegal got %b want 1", ill); end
        n_checks++;
        if (res !== 32'h0) begin n_fail++; $display("FAIL nodiv_result got %h want 0", res); end
        run_op(3'b111, 32'd100, 32'd7, res, lat, bok, ill);
        n_checks++;
        if (lat != 1 || ill !== 1'b1) begin n_fail++; $display("FAIL nodiv_remu lat/illegal got %0d/%b want 1/1", lat, ill); end
        run_op(3'b000, 32'd3, 32'd4, res, lat, bok, ill);
        n_checks++;
        if (res !== 32'd12) begin n_fail++; $display("FAIL nodiv_mul_result got %h want 0000000c", res); end
        n_checks++;
        if (ill !== 1'b0) begin n_fail++; $display("FAIL nodiv_mul_illegal got %b want 0", ill); end
        n_checks++;
        if (lat != 33) begin n_fail++; $display("FAIL nodiv_mul_latency got %0d want 33", lat); end
    endtask
`endif

    task automatic test_busy_start();
        int lat;
        tick();
        funct3 = 3'b000;
        a      = 32'd6;
        b      = 32'd7;
        start  = 1'b1;
        tick();
        start = 1'b0;
        lat   = 0;
        repeat (4) begin tick(); lat++; end
        funct3 = 3'b011;
        a      = 32'hFFFFFFFF;
        b      = 32'hFFFFFFFF;
        start  = 1'b1;
        tick();
        lat++;
        start = 1'b0;
        while (!done && lat < 100) begin tick(); lat++; end
        n_checks++;
        if (result !== 32'd42) begin n_fail++; $display("FAIL busy_start_result got %h want 0000002a", result); end
        n_checks++;
        if (lat != 33) begin n_fail++; $display("FAIL busy_start_latency got %0d want 33", lat); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        int          lat;
        bit          bok;
        logic        ill;
        run_op(3'b000, 32'd6, 32'd7, res, lat, bok, ill);
        funct3 = 3'b000;
        a      = 32'd5;
        b      = 32'd9;
        start  = 1'b1;
        tick();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_start_in_done_cycle busy got %b want 0", busy); end
        tick();
        start = 1'b0;
        lat   = 0;
        do begin tick(); lat++; end while (!done && lat < 100);
        n_checks++;
        if (lat != 33) begin n_fail++; $display("FAIL b2b_latency got %0d want 33", lat); end
        n_checks++;
        if (result !== 32'd45) begin n_fail++; $display("FAIL b2b_result got %h want 0000002d", result); end
    endtask

    task automatic test_reset_mid();
        int done_seen;
        tick();
        funct3 = 3'b011;
        a      = 32'h0000FFFF;
        b      = 32'h0000FFFF;
        start  = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid_busy got %b want 0", busy); end
        n_checks++;
        if (result !== 32'h0) begin n_fail++; $display("FAIL reset_mid_result got %h want 0", result); end
        reset     = 1'b0;
        done_seen = 0;
        repeat (40) begin
            tick();
            if (done) done_seen++;
        end
        n_checks++;
        if (done_seen != 0) begin n_fail++; $display("FAIL reset_mid_done got %0d pulses want 0", done_seen); end
    endtask

    initial begin
        test_reset();
        test_mul();
`ifdef MDU_DIV_EN
        test_div();
`else
        test_div_disabled();
`endif
        test_busy_start();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
